// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic conflict monitor: lamp codes, movement
// indices, the conflicting-movement table, fault codes and FSM states.
package traffic_pkg;

  // Lamp code bits: [2] red, [1] amber, [0] green. Exactly one bit may be set.
  localparam logic [2:0] LAMP_RED   = 3'b100;
  localparam logic [2:0] LAMP_AMBER = 3'b010;
  localparam logic [2:0] LAMP_GREEN = 3'b001;
  localparam logic [2:0] LAMP_OFF   = 3'b000;

  localparam int unsigned NUM_MOV = 6;

  // Movement indices
  localparam logic [2:0] MOV_W_TO_E = 3'd0;
  localparam logic [2:0] MOV_W_TO_N = 3'd1;
  localparam logic [2:0] MOV_E_TO_W = 3'd2;
  localparam logic [2:0] MOV_E_TO_N = 3'd3;
  localparam logic [2:0] MOV_N_TO_E = 3'd4;
  localparam logic [2:0] MOV_N_TO_W = 3'd5;

  // Movement pairs that must never be green together; PAIR_LO is always the
  // lower index, which is also the index reported for a conflict.
  localparam int unsigned NUM_PAIRS = 8;
  localparam logic [2:0] PAIR_LO [0:NUM_PAIRS-1] =
    '{3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd3, 3'd3, 3'd1};
  localparam logic [2:0] PAIR_HI [0:NUM_PAIRS-1] =
    '{3'd3, 3'd4, 3'd5, 3'd4, 3'd5, 3'd4, 3'd5, 3'd4};

  // Fault codes
  localparam logic [1:0] FC_NONE        = 2'b00;
  localparam logic [1:0] FC_CONFLICT    = 2'b01;
  localparam logic [1:0] FC_BAD_ENC     = 2'b10;
  localparam logic [1:0] FC_SHORT_AMBER = 2'b11;

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_MON     = 2'd1,
    ST_FLASH   = 2'd2,
    ST_RECOVER = 2'd3
  } mon_state_e;

  // True for the three one-hot lamp codes.
  function automatic logic lamp_legal(input logic [2:0] lamp);
    return (lamp == LAMP_RED) || (lamp == LAMP_AMBER) || (lamp == LAMP_GREEN);
  endfunction

endpackage

// File: rtl/movement_checker.sv
// Per-movement checker: flags illegal lamp codes and amber intervals that end
// in red too early (including green going straight to red).
module movement_checker
  import traffic_pkg::*;
#(
  parameter int AMBER_MIN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic [2:0] i_lamp,
  output logic       o_bad_enc,
  output logic       o_short_amber,
  output logic       o_is_green,
  output logic       o_is_red
);

  localparam int CW = $clog2(AMBER_MIN + 1);

  logic [CW-1:0] r_amber_cnt;
  logic          r_prev_green;
  logic          w_is_amber;

  assign w_is_amber = (i_lamp == LAMP_AMBER);
  assign o_is_green = (i_lamp == LAMP_GREEN);
  assign o_is_red   = (i_lamp == LAMP_RED);
  assign o_bad_enc  = !lamp_legal(i_lamp);

  // A nonzero count means the previous cycle was amber, so a red now with a
  // count below the minimum is an amber interval that was cut short.
  assign o_short_amber = o_is_red &&
    (r_prev_green || ((r_amber_cnt != '0) && (r_amber_cnt < CW'(AMBER_MIN))));

  // Track consecutive amber cycles (saturating) and whether last cycle was green.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_amber_cnt  <= '0;
      r_prev_green <= 1'b0;
    end else if (i_clear) begin
      r_amber_cnt  <= '0;
      r_prev_green <= 1'b0;
    end else begin
      r_prev_green <= o_is_green;
      if (!w_is_amber)
        r_amber_cnt <= '0;
      else if (r_amber_cnt != CW'(AMBER_MIN))
        r_amber_cnt <= r_amber_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Safety stage between the traffic controller and the lamp drivers. Passes lamp
// commands through one register while monitoring for bad codes, conflicting
// greens and short ambers; on a fault it latches the cause and flashes red
// until an operator clear followed by a verified all-red interval.
module traffic_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int AMBER_MIN  = 3,
  parameter int ALLRED_MIN = 2,
  parameter int FLASH_HALF = 5,
  parameter int PERSIST    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] w_to_e_in,
  input  logic [2:0] w_to_n_in,
  input  logic [2:0] e_to_w_in,
  input  logic [2:0] e_to_n_in,
  input  logic [2:0] n_to_e_in,
  input  logic [2:0] n_to_w_in,
  input  logic       clr,
  output logic [2:0] w_to_e,
  output logic [2:0] w_to_n,
  output logic [2:0] e_to_w,
  output logic [2:0] e_to_n,
  output logic [2:0] n_to_e,
  output logic [2:0] n_to_w,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [2:0] fault_idx,
  output logic [1:0] state_dbg
);

  localparam int PW = $clog2(PERSIST + 1);
  localparam int AW = $clog2(ALLRED_MIN + 1);
  localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [NUM_MOV-1:0][2:0] ALL_RED = {NUM_MOV{LAMP_RED}};
  localparam logic [NUM_MOV-1:0][2:0] ALL_OFF = {NUM_MOV{LAMP_OFF}};

  mon_state_e                r_state, w_state_nx;
  logic [NUM_MOV-1:0][2:0]   w_in, r_out, w_out_nx;
  logic [NUM_MOV-1:0]        w_bad, w_short, w_green, w_red;
  logic                      w_mon_entry, w_all_red, w_ar_done;
  logic                      w_conflict, w_persist_hit;
  logic [2:0]                w_conf_idx, w_bad_idx, w_short_idx;
  logic                      w_fault_now;
  logic [1:0]                w_code_nx;
  logic [2:0]                w_idx_nx;
  logic [PW-1:0]             r_persist, w_persist_nx;
  logic [AW-1:0]             r_allred, w_allred_nx;
  logic [FW-1:0]             r_flash_cnt, w_flash_cnt_nx;
  logic                      r_flash_on, w_flash_on_nx;
  logic                      r_fault;
  logic [1:0]                r_code;
  logic [2:0]                r_idx;

  assign w_in[MOV_W_TO_E] = w_to_e_in;
  assign w_in[MOV_W_TO_N] = w_to_n_in;
  assign w_in[MOV_E_TO_W] = e_to_w_in;
  assign w_in[MOV_E_TO_N] = e_to_n_in;
  assign w_in[MOV_N_TO_E] = n_to_e_in;
  assign w_in[MOV_N_TO_W] = n_to_w_in;

  // Monitor-side counters restart on every way into MON.
  assign w_mon_entry = (w_state_nx == ST_MON) && (r_state != ST_MON);

  for (genvar g = 0; g < NUM_MOV; g++) begin : g_chk
    movement_checker #(.AMBER_MIN(AMBER_MIN)) u_chk (
      .clk          (clk),
      .rst          (rst),
      .i_clear      (w_mon_entry),
      .i_lamp       (w_in[g]),
      .o_bad_enc    (w_bad[g]),
      .o_short_amber(w_short[g]),
      .o_is_green   (w_green[g]),
      .o_is_red     (w_red[g])
    );
  end

  assign w_all_red = &w_red;
  assign w_ar_done = w_all_red && (r_allred >= AW'(ALLRED_MIN - 1));

  // Conflict matrix: any forbidden pair green now; report lowest lower index.
  always_comb begin
    w_conflict = 1'b0;
    w_conf_idx = 3'd7;
    for (int p = 0; p < NUM_PAIRS; p++) begin
      if (w_green[PAIR_LO[p]] && w_green[PAIR_HI[p]]) begin
        w_conflict = 1'b1;
        if (PAIR_LO[p] < w_conf_idx) w_conf_idx = PAIR_LO[p];
      end
    end
  end

  assign w_persist_hit = w_conflict && (r_persist >= PW'(PERSIST - 1));

  // Priority encoder: bad encoding, then conflict, then short amber; lowest index wins.
  always_comb begin
    w_bad_idx   = '0;
    w_short_idx = '0;
    for (int i = NUM_MOV - 1; i >= 0; i--) begin
      if (w_bad[i])   w_bad_idx   = 3'(i);
      if (w_short[i]) w_short_idx = 3'(i);
    end
    w_fault_now = 1'b1;
    if (|w_bad) begin
      w_code_nx = FC_BAD_ENC;
      w_idx_nx  = w_bad_idx;
    end else if (w_persist_hit) begin
      w_code_nx = FC_CONFLICT;
      w_idx_nx  = w_conf_idx;
    end else if (|w_short) begin
      w_code_nx = FC_SHORT_AMBER;
      w_idx_nx  = w_short_idx;
    end else begin
      w_fault_now = 1'b0;
      w_code_nx   = FC_NONE;
      w_idx_nx    = '0;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_STARTUP, ST_RECOVER: if (w_ar_done)   w_state_nx = ST_MON;
      ST_MON:                 if (w_fault_now) w_state_nx = ST_FLASH;
      ST_FLASH:               if (clr)         w_state_nx = ST_RECOVER;
      default:                                 w_state_nx = ST_STARTUP;
    endcase
  end

  // Counter next values: each counter only runs while staying in its own state.
  always_comb begin
    w_allred_nx    = '0;
    w_persist_nx   = '0;
    w_flash_cnt_nx = '0;
    w_flash_on_nx  = 1'b1;
    if ((r_state == ST_STARTUP || r_state == ST_RECOVER) &&
        (w_state_nx == r_state) && w_all_red)
      w_allred_nx = r_allred + 1'b1;
    if (r_state == ST_MON && w_state_nx == ST_MON && w_conflict)
      w_persist_nx = r_persist + 1'b1;
    if (r_state == ST_FLASH && w_state_nx == ST_FLASH) begin
      if (r_flash_cnt == FW'(FLASH_HALF - 1)) begin
        w_flash_cnt_nx = '0;
        w_flash_on_nx  = ~r_flash_on;
      end else begin
        w_flash_cnt_nx = r_flash_cnt + 1'b1;
        w_flash_on_nx  = r_flash_on;
      end
    end
  end

  // Field drive: pass-through only while staying in MON with no fault.
  always_comb begin
    w_out_nx = ALL_RED;
    if (r_state == ST_MON && w_state_nx == ST_MON)
      w_out_nx = w_in;
    else if (w_state_nx == ST_FLASH)
      w_out_nx = w_flash_on_nx ? ALL_RED : ALL_OFF;
  end

  // State, counters and output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_STARTUP;
      r_allred    <= '0;
      r_persist   <= '0;
      r_flash_cnt <= '0;
      r_flash_on  <= 1'b1;
      r_out       <= ALL_RED;
    end else begin
      r_state     <= w_state_nx;
      r_allred    <= w_allred_nx;
      r_persist   <= w_persist_nx;
      r_flash_cnt <= w_flash_cnt_nx;
      r_flash_on  <= w_flash_on_nx;
      r_out       <= w_out_nx;
    end
  end

  // Fault latch: set on detection in MON, cleared only on RECOVER -> MON.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fault <= 1'b0;
      r_code  <= FC_NONE;
      r_idx   <= '0;
    end else if (r_state == ST_MON && w_fault_now) begin
      r_fault <= 1'b1;
      r_code  <= w_code_nx;
      r_idx   <= w_idx_nx;
    end else if (r_state == ST_RECOVER && w_state_nx == ST_MON) begin
      r_fault <= 1'b0;
      r_code  <= FC_NONE;
      r_idx   <= '0;
    end
  end

  assign w_to_e     = r_out[MOV_W_TO_E];
  assign w_to_n     = r_out[MOV_W_TO_N];
  assign e_to_w     = r_out[MOV_E_TO_W];
  assign e_to_n     = r_out[MOV_E_TO_N];
  assign n_to_e     = r_out[MOV_N_TO_E];
  assign n_to_w     = r_out[MOV_N_TO_W];
  assign fault      = r_fault;
  assign fault_code = r_code;
  assign fault_idx  = r_idx;
  assign state_dbg  = r_state;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Bench for traffic_conflict_monitor: directed scenarios followed by random
// traffic, all compared against a history-based reference model.
module tb_traffic_conflict_monitor;

  localparam int AMBER_MIN  = 3;
  localparam int ALLRED_MIN = 2;
  localparam int FLASH_HALF = 5;
  localparam int PERSIST    = 2;

  localparam logic [2:0]  R = 3'b100;
  localparam logic [2:0]  A = 3'b010;
  localparam logic [2:0]  G = 3'b001;
  localparam logic [17:0] ALL_RED = {6{3'b100}};
  localparam int PLO [8] = '{0, 0, 0, 2, 2, 3, 3, 1};
  localparam int PHI [8] = '{3, 4, 5, 4, 5, 4, 5, 4};

  localparam int M_STARTUP = 0, M_MON = 1, M_FLASH = 2, M_RECOVER = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i;
  logic        clr_i;
  logic [17:0] drv;
  logic [2:0]  o_we, o_wn, o_ew, o_en, o_ne, o_nw;
  logic        fault;
  logic [1:0]  fault_code;
  logic [2:0]  fault_idx;
  logic [1:0]  st_dbg;
  logic [17:0] obs_lamps;

  assign obs_lamps = {o_nw, o_ne, o_en, o_ew, o_wn, o_we};

  traffic_conflict_monitor #(
    .AMBER_MIN (AMBER_MIN),
    .ALLRED_MIN(ALLRED_MIN),
    .FLASH_HALF(FLASH_HALF),
    .PERSIST   (PERSIST)
  ) dut (
    .clk       (clk),
    .rst       (rst_i),
    .w_to_e_in (drv[2:0]),
    .w_to_n_in (drv[5:3]),
    .e_to_w_in (drv[8:6]),
    .e_to_n_in (drv[11:9]),
    .n_to_e_in (drv[14:12]),
    .n_to_w_in (drv[17:15]),
    .clr       (clr_i),
    .w_to_e    (o_we),
    .w_to_n    (o_wn),
    .e_to_w    (o_ew),
    .e_to_n    (o_en),
    .n_to_e    (o_ne),
    .n_to_w    (o_nw),
    .fault     (fault),
    .fault_code(fault_code),
    .fault_idx (fault_idx),
    .state_dbg (st_dbg)
  );

  // ---------------- reference model ----------------
  int          m_mode;
  logic [17:0] m_out;
  logic        m_fault;
  logic [1:0]  m_code;
  logic [2:0]  m_idx;
  int          m_run;
  int          m_t;
  logic [17:0] m_hist[$];   // inputs seen since the current MON period began

  function automatic logic [2:0] lmp(input logic [17:0] v, input int i);
    return v[3*i +: 3];
  endfunction

  function automatic logic any_conflict(input logic [17:0] v);
    for (int p = 0; p < 8; p++)
      if (lmp(v, PLO[p]) == G && lmp(v, PHI[p]) == G) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [17:0] set_mv(input logic [17:0] v, input int i, input logic [2:0] l);
    logic [17:0] r;
    r = v;
    r[3*i +: 3] = l;
    return r;
  endfunction

  task automatic model_reset();
    m_mode = M_STARTUP; m_out = ALL_RED; m_fault = 1'b0; m_code = 2'b00;
    m_idx = 3'd0; m_run = 0; m_t = 0; m_hist.delete();
  endtask

  // Advance the model by one clock with input v and clear c.
  task automatic model_step(input logic [17:0] v, input logic c);
    logic       hit;
    logic [1:0] code;
    logic [2:0] idx;
    logic [2:0] l;
    int         run, k, h;
    case (m_mode)
      M_STARTUP, M_RECOVER: begin
        m_out = ALL_RED;
        if (v == ALL_RED) m_run++; else m_run = 0;
        if (m_run == ALLRED_MIN) begin
          m_mode = M_MON; m_run = 0; m_hist.delete();
          m_fault = 1'b0; m_code = 2'b00; m_idx = 3'd0;
        end
      end
      M_MON: begin
        hit = 1'b0; code = 2'b00; idx = 3'd0;
        for (int i = 5; i >= 0; i--) begin
          l = lmp(v, i);
          if (!(l == R || l == A || l == G)) begin hit = 1'b1; code = 2'b10; idx = 3'(i); end
        end
        if (!hit && any_conflict(v)) begin
          run = 1;
          h = m_hist.size() - 1;
          while (h >= 0 && any_conflict(m_hist[h])) begin run++; h--; end
          if (run >= PERSIST) begin
            hit = 1'b1; code = 2'b01; idx = 3'd7;
            for (int p = 0; p < 8; p++)
              if (lmp(v, PLO[p]) == G && lmp(v, PHI[p]) == G && PLO[p] < int'(idx)) idx = 3'(PLO[p]);
          end
        end
        if (!hit && m_hist.size() > 0) begin
          for (int i = 5; i >= 0; i--) begin
            if (lmp(v, i) == R) begin
              k = 0;
              h = m_hist.size() - 1;
              while (h >= 0 && lmp(m_hist[h], i) == A) begin k++; h--; end
              if (lmp(m_hist[m_hist.size()-1], i) == G || (k > 0 && k < AMBER_MIN)) begin
                hit = 1'b1; code = 2'b11; idx = 3'(i);
              end
            end
          end
        end
        if (hit) begin
          m_mode = M_FLASH; m_t = 0; m_fault = 1'b1; m_code = code; m_idx = idx; m_out = ALL_RED;
        end else begin
          m_out = v;
          m_hist.push_back(v);
        end
      end
      default: begin
        if (c) begin
          m_mode = M_RECOVER; m_run = 0; m_out = ALL_RED;
        end else begin
          m_t++;
          m_out = (((m_t / FLASH_HALF) % 2) == 0) ? ALL_RED : 18'd0;
        end
      end
    endcase
  endtask

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("lamps", obs_lamps, m_out);
    chk("fault", 18'(fault), 18'(m_fault));
    chk("fault_code", 18'(fault_code), 18'(m_code));
    chk("fault_idx", 18'(fault_idx), 18'(m_idx));
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [17:0] v, input logic c);
    drv   = v;
    clr_i = c;
    model_step(v, c);
    @(posedge clk);
    #1;
    check_all();
  endtask

  logic [17:0] g0, a0, conf, enc_v, cur, rv;
  logic        rc;
  int          mv, r;

  initial begin
    rst_i = 1'b0; clr_i = 1'b0; drv = ALL_RED;
    model_reset();
    #12;
    check_all();
    rst_i = 1'b1;

    g0   = set_mv(ALL_RED, 0, G);
    a0   = set_mv(ALL_RED, 0, A);
    conf = set_mv(g0, 5, G);

    // Startup: two all-red cycles enter MON, then pass-through.
    step(ALL_RED, 1'b0);
    step(ALL_RED, 1'b0);
    step(g0, 1'b0);
    chk("passthru_w_to_e", 18'(o_we), 18'(G));
    chk("passthru_fault", 18'(fault), 18'd0);

    // One-cycle conflict is filtered; n_to_w leaves green properly via amber.
    step(conf, 1'b0);
    chk("short_conflict_fault", 18'(fault), 18'd0);
    for (int i = 0; i < 3; i++) step(set_mv(g0, 5, A), 1'b0);
    step(g0, 1'b0);

    // Two-cycle conflict faults; then watch the flash pattern.
    step(conf, 1'b0);
    step(conf, 1'b0);
    chk("conflict_code", 18'(fault_code), 18'(2'b01));
    chk("conflict_idx", 18'(fault_idx), 18'd0);
    chk("conflict_lamps", obs_lamps, ALL_RED);
    for (int i = 0; i < 5; i++) step(conf, 1'b0);
    chk("flash_off_phase", obs_lamps, 18'd0);
    for (int i = 0; i < 6; i++) step(conf, 1'b0);

    // Clear while still green: RECOVER holds red and the fault flag.
    step(conf, 1'b1);
    chk("recover_fault", 18'(fault), 18'd1);
    step(conf, 1'b0);
    step(ALL_RED, 1'b0);
    step(conf, 1'b0);
    step(ALL_RED, 1'b0);
    step(ALL_RED, 1'b0);
    chk("recovered_fault", 18'(fault), 18'd0);
    chk("recovered_code", 18'(fault_code), 18'd0);

    // Two amber cycles are too short.
    step(g0, 1'b0);
    step(a0, 1'b0);
    step(a0, 1'b0);
    step(ALL_RED, 1'b0);
    chk("short_amber_code", 18'(fault_code), 18'(2'b11));
    chk("short_amber_idx", 18'(fault_idx), 18'd0);
    step(ALL_RED, 1'b1);
    step(ALL_RED, 1'b0);
    step(ALL_RED, 1'b0);

    // Three amber cycles are fine.
    step(g0, 1'b0);
    for (int i = 0; i < 3; i++) step(a0, 1'b0);
    step(ALL_RED, 1'b0);
    chk("full_amber_fault", 18'(fault), 18'd0);

    // Bad encoding outranks a simultaneous conflict.
    enc_v = set_mv(set_mv(g0, 2, 3'b011), 3, G);
    step(enc_v, 1'b0);
    chk("enc_code", 18'(fault_code), 18'(2'b10));
    chk("enc_idx", 18'(fault_idx), 18'd2);
    step(enc_v, 1'b0);
    step(enc_v, 1'b0);

    // Asynchronous reset mid-flash takes effect without a clock edge.
    #2;
    rst_i = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_rst_lamps", obs_lamps, ALL_RED);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    check_all();
    step(ALL_RED, 1'b0);
    step(ALL_RED, 1'b0);

    // Random traffic.
    cur = ALL_RED;
    for (int n = 0; n < 800; n++) begin
      rv = cur;
      rc = ($urandom_range(0, 9) == 0);
      if (m_mode == M_MON) begin
        if ($urandom_range(0, 2) == 0) begin
          mv = $urandom_range(0, 5);
          r  = $urandom_range(0, 15);
          rv = set_mv(rv, mv, (r < 5) ? R : (r < 10) ? A : (r < 15) ? G : 3'($urandom_range(0, 7)));
        end
      end else if (m_mode == M_FLASH) begin
        if ($urandom_range(0, 3) == 0) rv = 18'($urandom);
      end else begin
        rv = ($urandom_range(0, 4) != 0) ? ALL_RED : set_mv(ALL_RED, $urandom_range(0, 5), G);
      end
      cur = rv;
      step(rv, rc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
